// File: rtl/time_counter.sv
// 24-hour BCD time-of-day counter: 1 s prescaler with full carry and midnight wrap,
// plus button-driven field setting with auto-repeat in set mode.
module time_counter #(
   parameter int unsigned TICK_DIV   = 50_000_000,
   parameter int unsigned REPEAT_DLY = 25_000_000,
   parameter int unsigned REPEAT_PER = 5_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       add,
   input  logic       minus,
   input  logic [3:0] switch,
   output logic [7:0] hr,
   output logic [7:0] min,
   output logic [7:0] sec,
   output logic       secPulse
);

   localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [RW-1:0] DLY_LAST   = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] PER_LAST   = RW'(REPEAT_PER - 1);

   logic [1:0]    r_add_s;
   logic [1:0]    r_min_s;
   logic [1:0]    r_vld;
   logic          r_up_q;
   logic          r_dn_q;
   logic          r_set_q;
   logic [PW-1:0] r_presc;
   logic          r_rpt_on;
   logic          r_rpt_first;
   logic          r_rpt_dir;
   logic [RW-1:0] r_rpt_cnt;
   logic [7:0]    r_hr;
   logic [7:0]    r_min;
   logic [7:0]    r_sec;
   logic          r_pulse;

   logic          w_set;
   logic          w_up;
   logic          w_dn;
   logic          w_step_up;
   logic          w_step_dn;
   logic          w_tick;
   logic          w_rpt_fire;
   logic          w_inc;
   logic          w_dec;
   logic [PW-1:0] w_presc_n;
   logic          w_rpt_on_n;
   logic          w_rpt_first_n;
   logic          w_rpt_dir_n;
   logic [RW-1:0] w_rpt_cnt_n;
   logic [7:0]    w_hr_n;
   logic [7:0]    w_min_n;
   logic [7:0]    w_sec_n;

   function automatic logic [7:0] bcd_up(input logic [7:0] v, input logic [7:0] top);
      logic [7:0] r;
      if (v == top)
         r = 8'h00;
      else if (v[3:0] == 4'd9)
         r = {4'(v[7:4] + 4'd1), 4'd0};
      else
         r = {v[7:4], 4'(v[3:0] + 4'd1)};
      return r;
   endfunction

   function automatic logic [7:0] bcd_dn(input logic [7:0] v, input logic [7:0] top);
      logic [7:0] r;
      if (v == 8'h00)
         r = top;
      else if (v[3:0] == 4'd0)
         r = {4'(v[7:4] - 4'd1), 4'd9};
      else
         r = {v[7:4], 4'(v[3:0] - 4'd1)};
      return r;
   endfunction

   assign w_set     = switch[0];
   assign w_up      = ~r_add_s[1] &  r_min_s[1];
   assign w_dn      =  r_add_s[1] & ~r_min_s[1];
   assign w_step_up = w_set & w_up & ~r_up_q;
   assign w_step_dn = w_set & w_dn & ~r_dn_q;

   // Prescaler, auto-repeat timer and next time-of-day value.
   always_comb begin
      w_presc_n     = r_presc;
      w_tick        = 1'b0;
      w_rpt_on_n    = r_rpt_on;
      w_rpt_first_n = r_rpt_first;
      w_rpt_dir_n   = r_rpt_dir;
      w_rpt_cnt_n   = r_rpt_cnt;
      w_rpt_fire    = 1'b0;
      w_inc         = 1'b0;
      w_dec         = 1'b0;
      w_hr_n        = r_hr;
      w_min_n       = r_min;
      w_sec_n       = r_sec;

      // First run-mode edge after set mode still holds the prescaler at 0.
      if (w_set || r_set_q) begin
         w_presc_n = '0;
      end else if (r_presc == PRESC_LAST) begin
         w_presc_n = '0;
         w_tick    = 1'b1;
      end else begin
         w_presc_n = r_presc + PW'(1);
      end

      if (w_step_up || w_step_dn) begin
         w_rpt_on_n    = 1'b1;
         w_rpt_first_n = 1'b1;
         w_rpt_dir_n   = w_step_up;
         w_rpt_cnt_n   = '0;
      end else if (r_rpt_on && w_set && (r_rpt_dir ? w_up : w_dn)) begin
         if (r_rpt_cnt == (r_rpt_first ? DLY_LAST : PER_LAST)) begin
            w_rpt_fire    = 1'b1;
            w_rpt_first_n = 1'b0;
            w_rpt_cnt_n   = '0;
         end else begin
            w_rpt_cnt_n = r_rpt_cnt + RW'(1);
         end
      end else begin
         w_rpt_on_n    = 1'b0;
         w_rpt_first_n = 1'b1;
         w_rpt_cnt_n   = '0;
      end

      w_inc = w_step_up | (w_rpt_fire &  r_rpt_dir);
      w_dec = w_step_dn | (w_rpt_fire & ~r_rpt_dir);

      if (w_tick) begin
         w_sec_n = bcd_up(r_sec, 8'h59);
         if (r_sec == 8'h59) begin
            w_min_n = bcd_up(r_min, 8'h59);
            if (r_min == 8'h59)
               w_hr_n = bcd_up(r_hr, 8'h23);
         end
      end else if (w_inc || w_dec) begin
         if (switch[1]) w_hr_n  = w_inc ? bcd_up(r_hr,  8'h23) : bcd_dn(r_hr,  8'h23);
         if (switch[2]) w_min_n = w_inc ? bcd_up(r_min, 8'h59) : bcd_dn(r_min, 8'h59);
         if (switch[3]) w_sec_n = w_inc ? bcd_up(r_sec, 8'h59) : bcd_dn(r_sec, 8'h59);
      end
   end

   // Button synchronizers; edge detectors stay "pressed" until real samples arrive.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_add_s <= 2'b11;
         r_min_s <= 2'b11;
         r_vld   <= 2'b00;
         r_up_q  <= 1'b1;
         r_dn_q  <= 1'b1;
      end else begin
         r_add_s <= {r_add_s[0], add};
         r_min_s <= {r_min_s[0], minus};
         r_vld   <= {r_vld[0], 1'b1};
         r_up_q  <= r_vld[1] ? w_up : 1'b1;
         r_dn_q  <= r_vld[1] ? w_dn : 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_set_q     <= 1'b0;
         r_presc     <= '0;
         r_rpt_on    <= 1'b0;
         r_rpt_first <= 1'b1;
         r_rpt_dir   <= 1'b0;
         r_rpt_cnt   <= '0;
         r_hr        <= 8'h00;
         r_min       <= 8'h00;
         r_sec       <= 8'h00;
         r_pulse     <= 1'b0;
      end else begin
         r_set_q     <= w_set;
         r_presc     <= w_presc_n;
         r_rpt_on    <= w_rpt_on_n;
         r_rpt_first <= w_rpt_first_n;
         r_rpt_dir   <= w_rpt_dir_n;
         r_rpt_cnt   <= w_rpt_cnt_n;
         r_hr        <= w_hr_n;
         r_min       <= w_min_n;
         r_sec       <= w_sec_n;
         r_pulse     <= w_tick;
      end
   end

   assign hr       = r_hr;
   assign min      = r_min;
   assign sec      = r_sec;
   assign secPulse = r_pulse;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: hand vector table, randomized run against
// a seconds-of-day reference model, and a reset-while-held sequence.
module tb_time_counter;

   localparam int TD = 4;
   localparam int RD = 10;
   localparam int RP = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       add = 1'b1;
   logic       minus = 1'b1;
   logic [3:0] switch = 4'b0000;
   logic [7:0] hr;
   logic [7:0] min;
   logic [7:0] sec;
   logic       sec_pulse;

   int checks = 0;
   int failures = 0;

   time_counter #(.TICK_DIV(TD), .REPEAT_DLY(RD), .REPEAT_PER(RP)) dut (
      .clk(clk), .reset(reset), .add(add), .minus(minus), .switch(switch),
      .hr(hr), .min(min), .sec(sec), .secPulse(sec_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       rst;
      bit [3:0] sw;
      bit       a;
      bit       m;
      int       n;
      bit [7:0] eh;
      bit [7:0] em;
      bit [7:0] es;
      bit       ep;
   } vec_t;

   vec_t vt[$];

   // Reference model state: plain integers for the time, a queue for the synchronizer delay.
   int       m_hh, m_mm, m_ss;
   bit       m_pulse;
   bit [1:0] m_hist[$];
   bit       m_prev_up, m_prev_dn;
   int       m_age;
   bit       m_dir;
   bit       m_setp;
   int       m_run;

   function automatic void v(input bit rst, input bit [3:0] sw, input bit a, input bit m,
                             input int n, input bit [7:0] eh, input bit [7:0] em,
                             input bit [7:0] es, input bit ep);
      vec_t x;
      x.rst = rst; x.sw = sw; x.a = a; x.m = m; x.n = n;
      x.eh = eh; x.em = em; x.es = es; x.ep = ep;
      vt.push_back(x);
   endfunction

   function automatic logic [7:0] bcd(input int x);
      return 8'(((x / 10) * 16) + (x % 10));
   endfunction

   task automatic chk(input string name, input logic [7:0] eh, input logic [7:0] em,
                      input logic [7:0] es, input logic ep);
      checks++;
      if (hr !== eh || min !== em || sec !== es || sec_pulse !== ep) begin
         failures++;
         $display("FAIL %s t=%0t got %h:%h:%h pulse=%b expected %h:%h:%h pulse=%b",
                  name, $time, hr, min, sec, sec_pulse, eh, em, es, ep);
      end
   endtask

   // One clock edge of the reference model, using the inputs present at that edge.
   task automatic model_step();
      bit [1:0] vis;
      bit known, su, sd, pu, pd, rep, inc, dec, tk;
      int t;
      if (reset) begin
         m_hh = 0; m_mm = 0; m_ss = 0; m_pulse = 0;
         m_hist.delete();
         m_prev_up = 1; m_prev_dn = 1;
         m_age = -1; m_dir = 0; m_setp = 0; m_run = 0;
         return;
      end
      known = (m_hist.size() == 2);
      vis = known ? m_hist[0] : 2'b11;
      m_hist.push_back({add, minus});
      if (m_hist.size() > 2) void'(m_hist.pop_front());
      su = known && (vis == 2'b01);
      sd = known && (vis == 2'b10);
      pu = switch[0] && su && !m_prev_up;
      pd = switch[0] && sd && !m_prev_dn;
      m_prev_up = known ? su : 1'b1;
      m_prev_dn = known ? sd : 1'b1;

      rep = 0;
      if (pu || pd) begin
         m_age = 0;
         m_dir = pu;
      end else if (m_age >= 0) begin
         if (switch[0] && (m_dir ? su : sd)) begin
            m_age++;
            rep = (m_age == RD) || (m_age > RD && ((m_age - RD) % RP) == 0);
         end else begin
            m_age = -1;
         end
      end
      inc = pu || (rep && m_dir);
      dec = pd || (rep && !m_dir);

      tk = 0;
      if (switch[0]) begin
         m_run = 0; m_setp = 1;
      end else if (m_setp) begin
         m_run = 0; m_setp = 0;
      end else begin
         m_run++;
         tk = (m_run % TD) == 0;
      end

      if (inc || dec) begin
         if (switch[1]) m_hh = inc ? (m_hh + 1) % 24 : (m_hh + 23) % 24;
         if (switch[2]) m_mm = inc ? (m_mm + 1) % 60 : (m_mm + 59) % 60;
         if (switch[3]) m_ss = inc ? (m_ss + 1) % 60 : (m_ss + 59) % 60;
      end
      if (tk) begin
         t = ((m_hh * 60 + m_mm) * 60 + m_ss + 1) % 86400;
         m_hh = t / 3600;
         m_mm = (t / 60) % 60;
         m_ss = t % 60;
      end
      m_pulse = tk;
   endtask

   task automatic run_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         chk("model", bcd(m_hh), bcd(m_mm), bcd(m_ss), m_pulse);
      end
   endtask

   task automatic press(input logic [3:0] sw, input bit up);
      switch = sw;
      if (up) add = 1'b0; else minus = 1'b0;
      run_cyc(3);
      add = 1'b1;
      minus = 1'b1;
      run_cyc(3);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int dur;
      // rst sw a m n | hr min sec pulse
      v(1, 4'b0000, 1, 1,  2, 8'h00, 8'h00, 8'h00, 0);
      v(0, 4'b0000, 1, 1,  3, 8'h00, 8'h00, 8'h00, 0);
      v(0, 4'b0000, 1, 1,  1, 8'h00, 8'h00, 8'h01, 1);
      v(0, 4'b0000, 1, 1,  1, 8'h00, 8'h00, 8'h01, 0);
      v(0, 4'b0000, 1, 1,  3, 8'h00, 8'h00, 8'h02, 1);
      v(0, 4'b0011, 1, 1,  2, 8'h00, 8'h00, 8'h02, 0);
      v(0, 4'b0011, 0, 1,  2, 8'h00, 8'h00, 8'h02, 0);
      v(0, 4'b0011, 0, 1,  1, 8'h01, 8'h00, 8'h02, 0);
      v(0, 4'b0011, 1, 1,  3, 8'h01, 8'h00, 8'h02, 0);
      v(0, 4'b0101, 1, 0,  3, 8'h01, 8'h59, 8'h02, 0);
      v(0, 4'b0101, 1, 1,  3, 8'h01, 8'h59, 8'h02, 0);
      v(0, 4'b1001, 0, 1,  2, 8'h01, 8'h59, 8'h02, 0);
      v(0, 4'b1001, 0, 1,  1, 8'h01, 8'h59, 8'h03, 0);
      v(0, 4'b1001, 0, 1,  9, 8'h01, 8'h59, 8'h03, 0);
      v(0, 4'b1001, 0, 1,  1, 8'h01, 8'h59, 8'h04, 0);
      v(0, 4'b1001, 0, 1,  3, 8'h01, 8'h59, 8'h04, 0);
      v(0, 4'b1001, 0, 1,  1, 8'h01, 8'h59, 8'h05, 0);
      v(0, 4'b1001, 0, 0, 10, 8'h01, 8'h59, 8'h05, 0);
      v(0, 4'b1001, 1, 1,  3, 8'h01, 8'h59, 8'h05, 0);
      v(0, 4'b0000, 1, 1,  4, 8'h01, 8'h59, 8'h05, 0);
      v(0, 4'b0000, 1, 1,  1, 8'h01, 8'h59, 8'h06, 1);
      v(0, 4'b0000, 1, 1,  3, 8'h01, 8'h59, 8'h06, 0);
      v(0, 4'b0001, 1, 1,  1, 8'h01, 8'h59, 8'h06, 0);
      v(0, 4'b0000, 1, 1,  4, 8'h01, 8'h59, 8'h06, 0);
      v(0, 4'b0000, 1, 1,  1, 8'h01, 8'h59, 8'h07, 1);
      v(0, 4'b0000, 0, 1,  6, 8'h01, 8'h59, 8'h08, 0);
      v(0, 4'b0011, 0, 1,  5, 8'h01, 8'h59, 8'h08, 0);
      v(0, 4'b0011, 1, 1,  3, 8'h01, 8'h59, 8'h08, 0);
      v(0, 4'b0011, 0, 1,  5, 8'h02, 8'h59, 8'h08, 0);
      v(1, 4'b0011, 0, 1,  1, 8'h00, 8'h00, 8'h00, 0);
      v(0, 4'b0011, 0, 1, 20, 8'h00, 8'h00, 8'h00, 0);
      v(0, 4'b0011, 1, 1,  3, 8'h00, 8'h00, 8'h00, 0);
      v(0, 4'b0011, 0, 1,  3, 8'h01, 8'h00, 8'h00, 0);
      v(0, 4'b0011, 1, 1,  3, 8'h01, 8'h00, 8'h00, 0);
      v(0, 4'b1111, 1, 0,  3, 8'h00, 8'h59, 8'h59, 0);
      v(0, 4'b1111, 1, 1,  3, 8'h00, 8'h59, 8'h59, 0);
      v(0, 4'b0000, 1, 1,  4, 8'h00, 8'h59, 8'h59, 0);
      v(0, 4'b0000, 1, 1,  1, 8'h01, 8'h00, 8'h00, 1);
      v(0, 4'b1111, 1, 0,  3, 8'h00, 8'h59, 8'h59, 0);
      v(0, 4'b1111, 1, 1,  3, 8'h00, 8'h59, 8'h59, 0);
      v(0, 4'b0011, 1, 0,  3, 8'h23, 8'h59, 8'h59, 0);
      v(0, 4'b0011, 1, 1,  3, 8'h23, 8'h59, 8'h59, 0);
      v(0, 4'b0000, 1, 1,  4, 8'h23, 8'h59, 8'h59, 0);
      v(0, 4'b0000, 1, 1,  1, 8'h00, 8'h00, 8'h00, 1);

      foreach (vt[i]) begin
         reset  = vt[i].rst;
         switch = vt[i].sw;
         add    = vt[i].a;
         minus  = vt[i].m;
         repeat (vt[i].n) @(negedge clk);
         chk($sformatf("vec%0d", i), vt[i].eh, vt[i].em, vt[i].es, vt[i].ep);
      end

      // Randomized segments against the reference model.
      reset = 1'b1; add = 1'b1; minus = 1'b1; switch = 4'b0000;
      run_cyc(2);
      reset = 1'b0;
      for (int seg = 0; seg < 250; seg++) begin
         reset  = ($urandom_range(0, 99) < 3);
         dur    = reset ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 40));
         switch = 4'($urandom_range(0, 15));
         add    = ($urandom_range(0, 2) == 0);
         minus  = ($urandom_range(0, 3) != 0);
         run_cyc(dur);
      end

      // Set 12:34:56, hold add with no field selected, then reset mid-hold.
      reset = 1'b1; add = 1'b1; minus = 1'b1; switch = 4'b0000;
      run_cyc(2);
      reset = 1'b0;
      switch = 4'b0011;
      run_cyc(2);
      repeat (12) press(4'b0011, 1'b1);
      repeat (26) press(4'b0101, 1'b0);
      repeat (4)  press(4'b1001, 1'b0);
      chk("set_12_34_56", 8'h12, 8'h34, 8'h56, 1'b0);
      switch = 4'b0001;
      add = 1'b0;
      run_cyc(15);
      chk("no_field_selected", 8'h12, 8'h34, 8'h56, 1'b0);
      switch = 4'b0011;
      reset = 1'b1;
      run_cyc(1);
      chk("reset_mid_hold", 8'h00, 8'h00, 8'h00, 1'b0);
      reset = 1'b0;
      run_cyc(20);
      chk("held_through_reset", 8'h00, 8'h00, 8'h00, 1'b0);
      add = 1'b1;
      run_cyc(3);
      add = 1'b0;
      run_cyc(3);
      chk("repress_after_reset", 8'h01, 8'h00, 8'h00, 1'b0);
      add = 1'b1;
      run_cyc(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
